// File: rtl/audio_burst_reader_if.sv
// audio_burst_reader_if: Avalon-MM read bus plus ready/valid sample stream of the audio burst reader.
interface audio_burst_reader_if;
   logic [17:0] avm_address;
   logic        avm_read;
   logic [3:0]  avm_burstcount;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;
   logic [31:0] sample_data;
   logic        sample_valid;
   logic        sample_ready;
   modport master (
      output avm_address, avm_read, avm_burstcount, sample_data, sample_valid,
      input  avm_waitrequest, avm_readdata, avm_readdatavalid, sample_ready
   );
   modport slave (
      input  avm_address, avm_read, avm_burstcount, sample_data, sample_valid,
      output avm_waitrequest, avm_readdata, avm_readdatavalid, sample_ready
   );
endinterface

// File: rtl/audio_burst_reader.sv
// audio_burst_reader: Avalon-MM burst read master feeding a sample FIFO; AUDIO_READER_LOOP_EN enables gapless looping.
module audio_burst_reader #(
   parameter int BURST_LEN  = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic        start,
   input  logic        stop,
   input  logic [17:0] start_addr,
   input  logic [17:0] length,
   output logic        busy,
   output logic        done,
   audio_burst_reader_if.master bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [2:0] {IDLE, REQ, DATA, DRAIN, ABORT} state_t;
   state_t state, state_n;
   logic [17:0] addr, remaining, start_a, len_r;
   logic [3:0] beats, bs;
   logic pend, pend_n, load, reload, acc, flush, done_n, beat, last, push, pop;
   logic [AW:0] count, space;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [31:0] mem [FIFO_DEPTH];
   assign bs = remaining < 18'(BURST_LEN) ? remaining[3:0] : 4'(BURST_LEN);
   assign space = (AW+1)'(FIFO_DEPTH) - count;
   assign bus.avm_read = state == REQ && space >= (AW+1)'(bs);
   assign bus.avm_burstcount = bus.avm_read ? bs : '0;
   assign bus.avm_address = addr;
   assign acc = bus.avm_read && !bus.avm_waitrequest;
   assign beat = bus.avm_readdatavalid && (state == DATA || state == ABORT);
   assign last = beat && beats == 4'd1;
   assign push = bus.avm_readdatavalid && state == DATA;
   // a pending abort hides the FIFO so nothing leaks out while the held request drains
   assign bus.sample_valid = count != '0 && state != ABORT && !pend;
   assign bus.sample_data = mem[rd_ptr];
   assign pop = bus.sample_valid && bus.sample_ready;
   assign busy = state != IDLE;
   always_comb begin
      state_n = state;
      pend_n = pend;
      load = 1'b0;
      reload = 1'b0;
      flush = 1'b0;
      done_n = 1'b0;
      case (state)
         IDLE: if (start && length != '0) begin
            load = 1'b1;
            pend_n = 1'b0;
            state_n = REQ;
         end
         REQ: if (acc) state_n = (pend || stop) ? ABORT : DATA;
            else if (stop && !bus.avm_read) begin
               flush = 1'b1;
               done_n = 1'b1;
               state_n = IDLE;
            end
            else if (stop) pend_n = 1'b1;
         DATA: if (stop) state_n = ABORT;
`ifdef AUDIO_READER_LOOP_EN
            else if (last && remaining == '0) begin
               reload = 1'b1;
               state_n = REQ;
            end
`else
            else if (last && remaining == '0) state_n = DRAIN;
`endif
            else if (last) state_n = REQ;
         DRAIN: if (stop || count == '0) begin
            flush = 1'b1;
            done_n = 1'b1;
            state_n = IDLE;
         end
         ABORT: if (beats == '0) begin
            flush = 1'b1;
            done_n = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state <= IDLE;
         pend <= 1'b0;
         done <= 1'b0;
      end else begin
         state <= state_n;
         pend <= pend_n;
         done <= done_n;
      end
   end
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         addr <= '0;
         remaining <= '0;
         start_a <= '0;
         len_r <= '0;
         beats <= '0;
      end else begin
         if (load) begin
            addr <= start_addr;
            remaining <= length;
            start_a <= start_addr;
            len_r <= length;
         end else if (reload) begin
            addr <= start_a;
            remaining <= len_r;
         end else if (acc) begin
            addr <= addr + 18'(bs);
            remaining <= remaining - 18'(bs);
         end
         beats <= acc ? bs : beats - 4'(beat);
      end
   end
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (push) mem[wr_ptr] <= bus.avm_readdata;
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
endmodule

// File: doc/audio_burst_reader.md
# audio_burst_reader

Avalon-MM burst read master that plays a stored audio ident out of the on-chip audio storage memory (18-bit word address, 32-bit data, 4-bit burstcount). On a start command it fetches a configurable range of sample words in bursts, buffers them in an internal FIFO, and presents them on a ready/valid sample stream to the audio output path. It is the only master on the storage read port and sequences all of its traffic.

## Interface
- BURST_LEN, 8: maximum words per burst, 1..15.
- FIFO_DEPTH, 16: sample FIFO depth in words, power of two, >= 2*BURST_LEN.
- clk_clk  in  1  single system clock; all logic rising-edge.
- reset_reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- stop  in  1  one-cycle pulse; aborts playback in any non-IDLE state.
- start_addr  in  18  first word address, sampled on accepted start.
- length  in  18  words to play, sampled on accepted start; 0 = ignore start.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a play completes or an abort finishes.
- avm_address  out  18  word address of the current burst.
- avm_read  out  1  read request.
- avm_burstcount  out  4  beats in the current burst.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data beat valid.
- sample_data  out  32  FIFO head word.
- sample_valid  out  1  FIFO not empty and not flushing.
- sample_ready  in  1  consumer accepts word when valid&ready.

## Operation
- States: IDLE, REQ, DATA, DRAIN, ABORT.
- IDLE: start with length!=0 -> load addr=start_addr, remaining=length -> REQ (if free space allows, else stay in REQ with avm_read low).
- REQ: burst size bs=min(BURST_LEN, remaining). Assert avm_read with avm_address=addr, avm_burstcount=bs only when FIFO free space (depth minus occupancy) >= bs. Once asserted, address/burstcount/read held constant until waitrequest low. On acceptance: addr+=bs (mod 2^18, wraps 0x3FFFF->0), remaining-=bs, beats=bs -> DATA.
- DATA: each readdatavalid writes readdata to FIFO, beats-=1. At last beat: remaining!=0 -> REQ, else DRAIN. One burst outstanding at most.
- DRAIN: wait for FIFO empty -> pulse done, IDLE.
- stop in REQ with avm_read high and waitrequest high: read held until accepted (Avalon rule), then ABORT with beats=bs. stop in REQ with read low -> immediate flush, done, IDLE. stop in DATA -> ABORT. stop in DRAIN -> flush, done, IDLE.
- ABORT: beats counted but discarded; sample_valid low; when beats=0 flush FIFO, pulse done, IDLE.
- start while busy ignored; start and stop same cycle in IDLE: start wins, stop ignored. stop in IDLE ignored.
- FIFO never overflows by construction (space checked before request); readdatavalid while FIFO full is impossible and not handled.

## Timing
- Reset values: busy 0, done 0, avm_read 0, avm_address 0, avm_burstcount 0, sample_valid 0, sample_data 0; FIFO empty; state IDLE.
- Accepted start -> avm_read high next cycle (FIFO empty, space available).
- FIFO write -> sample_valid earliest next cycle; FIFO read and write same cycle allowed, occupancy unchanged.
- sample_data registered, stable while sample_valid high and sample_ready low.
- done high exactly one cycle; busy falls same cycle done rises.
- Next burst request earliest the cycle after the last beat of the previous burst.

## Configuration
- AUDIO_READER_LOOP_EN: defined -> when remaining reaches 0 at last beat, reload addr=start_addr, remaining=length and go to REQ (gapless loop); only stop ends playback, done only after abort. Not defined -> single pass as above.

## Test plan
- start_addr=0x00100, length=20, ready always 1 -> bursts (0x00100,8),(0x00108,8),(0x00110,4); 20 words out in order; done one pulse; busy low after.
- length=0 start -> no avm_read, busy stays 0, no done.
- waitrequest high 5 cycles on first burst -> address/burstcount/read stable all 5 cycles; stop during stall -> request held until accepted, 8 beats discarded, no sample_valid, done pulse, FIFO empty.
- sample_ready low, length=40 -> FIFO fills to 16, no request issued while free space <8; releasing ready resumes with no lost/duplicated words.
- start_addr=0x3FFFC, length=8 -> bursts (0x3FFFC,8) then none; next play from 0x3FFFE, length 10 -> second burst address 0x00006 (wrap).
- reset_reset asserted mid-DATA -> all outputs to reset values asynchronously; after release start works normally; with AUDIO_READER_LOOP_EN, length=3 -> data repeats word0..2 until stop.
